// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between the two caches and the unified memory responder.
// Latency: none; this is wiring only.
// Backpressure: carried by the combinational i_grant/d_grant signals. A request not granted must be held or dropped by the cache.
// Ports: I side: i_enable/i_addr in, i_grant/i_data_out/i_data_valid out.
//        D side: d_enable/d_wr/d_addr/d_data_in in, d_grant/d_data_out/d_data_valid out.
interface unified_mem_responder_if #(
  parameter int ADDR_W = 16
) ();
  logic              i_enable;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic [15:0]       i_data_out;
  logic              i_data_valid;
  logic              d_enable;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_data_in;
  logic              d_grant;
  logic [15:0]       d_data_out;
  logic              d_data_valid;

  // Cache side.
  modport master (
    output i_enable, i_addr,
    input  i_grant, i_data_out, i_data_valid,
    output d_enable, d_wr, d_addr, d_data_in,
    input  d_grant, d_data_out, d_data_valid
  );

  // Memory side.
  modport slave (
    input  i_enable, i_addr,
    output i_grant, i_data_out, i_data_valid,
    input  d_enable, d_wr, d_addr, d_data_in,
    output d_grant, d_data_out, d_data_valid
  );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-ported unified memory serving I-cache reads and D-cache reads/writes, with a lock-while-enabled round-robin arbiter.
// Latency: a read accepted in cycle n returns in cycle n+LATENCY with a one-cycle x_data_valid pulse. Writes produce no response.
// Backpressure: combinational grants. The owner keeps the grant while its enable stays high, and responses always drain.
// Ports: clk, rst (sync, active high), bus (slave modport of unified_mem_responder_if).
module unified_mem_responder #(
  parameter int ADDR_W         = 16,
  parameter int MEM_WORDS_LOG2 = 15,
  parameter int LATENCY        = 4
) (
  input logic                    clk,
  input logic                    rst,
  unified_mem_responder_if.slave bus
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic       TAG_I    = 1'b0;
  localparam logic       TAG_D    = 1'b1;
  localparam int         DEPTH    = 1 << MEM_WORDS_LOG2;
  // The output register is the last latency stage, so the shift pipe holds LATENCY-1 stages.
  localparam int         PIPE_D   = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic        vld;
    logic        tag;
    logic [15:0] dat;
  } pipe_t;

  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;
  pipe_t       pipe_q [PIPE_D];
  pipe_t       pipe_d [PIPE_D];
  logic        i_vld_q, i_vld_d, d_vld_q, d_vld_d;
  logic [15:0] i_dat_q, i_dat_d, d_dat_q, d_dat_d;
  logic [15:0] mem_q [DEPTH];

  logic                      grant_i, grant_d;
  logic [ADDR_W-1:0]         addr_sel;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic                      wr_en, rd_en;
  pipe_t                     head, tail;
  logic                      unused_addr_bits;

  // Arbitration: the current owner keeps the grant while enabled. Otherwise a lone requester wins.
  // On a tie, the requester that did not win most recently wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (owner_q == OWN_I && bus.i_enable) begin
      grant_i = 1'b1;
    end else if (owner_q == OWN_D && bus.d_enable) begin
      grant_d = 1'b1;
    end else if (bus.i_enable && bus.d_enable) begin
      if (last_q == TAG_I) grant_d = 1'b1;
      else                 grant_i = 1'b1;
    end else if (bus.i_enable) begin
      grant_i = 1'b1;
    end else if (bus.d_enable) begin
      grant_d = 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    if (grant_i) begin
      owner_d = OWN_I;
      if (owner_q != OWN_I) last_d = TAG_I;
    end else if (grant_d) begin
      owner_d = OWN_D;
      if (owner_q != OWN_D) last_d = TAG_D;
    end
  end

  // Single storage port. Only the granted requester's address reaches it.
  // Word addressing drops bit 0, and bits above the depth are ignored, which wraps the address space.
  always_comb begin
    addr_sel         = grant_d ? bus.d_addr : bus.i_addr;
    idx              = addr_sel[MEM_WORDS_LOG2:1];
    unused_addr_bits = ^addr_sel;
    wr_en            = grant_d & bus.d_wr & ~rst;
    rd_en            = grant_i | (grant_d & ~bus.d_wr);
  end

  // The head captures storage before this edge's write lands, which gives read-before-write behaviour.
  always_comb begin
    head.vld  = rd_en;
    head.tag  = grant_d ? TAG_D : TAG_I;
    head.dat  = mem_q[idx];
    pipe_d[0] = head;
    for (int k = 1; k < PIPE_D; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    if (LATENCY == 1) tail = head;
    else              tail = pipe_q[PIPE_D-1];
    i_vld_d = tail.vld & (tail.tag == TAG_I);
    d_vld_d = tail.vld & (tail.tag == TAG_D);
    i_dat_d = i_vld_d ? tail.dat : 16'h0000;
    d_dat_d = d_vld_d ? tail.dat : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q  <= TAG_I;
      for (int k = 0; k < PIPE_D; k++) begin
        pipe_q[k] <= '0;
      end
      i_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      i_dat_q <= 16'h0000;
      d_dat_q <= 16'h0000;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      for (int k = 0; k < PIPE_D; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
      i_vld_q <= i_vld_d;
      d_vld_q <= d_vld_d;
      i_dat_q <= i_dat_d;
      d_dat_q <= d_dat_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= bus.d_data_in;
  end

  assign bus.i_grant      = grant_i;
  assign bus.d_grant      = grant_d;
  assign bus.i_data_valid = i_vld_q;
  assign bus.d_data_valid = d_vld_q;
  assign bus.i_data_out   = i_dat_q;
  assign bus.d_data_out   = d_dat_q;
endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder. It runs a main instance (default depth) and a 16-word instance for address wrap.
// Expected responses are queued when a request is driven. They are compared in order against responses observed at negedge.
module tb_unified_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_responder_if #(.ADDR_W(16)) mif ();
  unified_mem_responder_if #(.ADDR_W(16)) smf ();

  unified_mem_responder #(.ADDR_W(16), .MEM_WORDS_LOG2(15), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(mif.slave));
  unified_mem_responder #(.ADDR_W(16), .MEM_WORDS_LOG2(4), .LATENCY(LAT)) dut_small (
    .clk(clk), .rst(rst), .bus(smf.slave));

  typedef struct {
    logic        tag;   // 0 = I, 1 = D
    logic [15:0] dat;
    int          cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  rsp_t sm_obs_q[$];
  int errors = 0, checks = 0, cyc = 0, dual_cnt = 0, stray_cnt = 0;
  logic g_i, g_d, o_iv, o_dv;
  logic [15:0] o_id, o_dd;

  // Advance one cycle. Sample outputs at negedge, then move to just after the next posedge.
  task automatic step();
    rsp_t r;
    @(negedge clk);
    g_i = mif.i_grant; g_d = mif.d_grant;
    o_iv = mif.i_data_valid; o_dv = mif.d_data_valid;
    o_id = mif.i_data_out; o_dd = mif.d_data_out;
    if (mif.i_data_valid) begin r.tag = 1'b0; r.dat = mif.i_data_out; r.cyc = cyc; obs_q.push_back(r); end
    if (mif.d_data_valid) begin r.tag = 1'b1; r.dat = mif.d_data_out; r.cyc = cyc; obs_q.push_back(r); end
    if (mif.i_data_valid && mif.d_data_valid) dual_cnt++;
    if ((!mif.i_data_valid && mif.i_data_out != 16'h0) || (!mif.d_data_valid && mif.d_data_out != 16'h0)) stray_cnt++;
    if (smf.d_data_valid) begin r.tag = 1'b1; r.dat = smf.d_data_out; r.cyc = cyc; sm_obs_q.push_back(r); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drive_i(input logic en, input logic [15:0] a);
    mif.i_enable = en; mif.i_addr = a;
  endtask

  task automatic drive_d(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] dat);
    mif.d_enable = en; mif.d_wr = wr; mif.d_addr = a; mif.d_data_in = dat;
  endtask

  task automatic push_exp(input logic tag, input logic [15:0] dat, input int c);
    rsp_t r;
    r.tag = tag; r.dat = dat; r.cyc = c;
    exp_q.push_back(r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++; if (o_iv !== 1'b0) begin errors++; $display("FAIL reset i_data_valid: got %b want 0", o_iv); end
    checks++; if (o_dv !== 1'b0) begin errors++; $display("FAIL reset d_data_valid: got %b want 0", o_dv); end
    checks++; if (o_id !== 16'h0) begin errors++; $display("FAIL reset i_data_out: got %h want 0000", o_id); end
    checks++; if (o_dd !== 16'h0) begin errors++; $display("FAIL reset d_data_out: got %h want 0000", o_dd); end
    checks++; if (g_i !== 1'b0 || g_d !== 1'b0) begin errors++; $display("FAIL reset idle_grants: got i=%b d=%b want 0 0", g_i, g_d); end
    drive_d(1'b1, 1'b1, 16'h0010, 16'h0000);
    step();
    checks++; if (g_d !== 1'b1 || g_i !== 1'b0) begin errors++; $display("FAIL reset d_only_grant: got i=%b d=%b want 0 1", g_i, g_d); end
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    step();
    obs_q.delete();
  endtask

  task automatic test_single_read();
    rsp_t e, o;
    drive_d(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step();
    drive_d(1'b1, 1'b0, 16'h0010, 16'h0000);
    push_exp(1'b1, 16'hBEEF, cyc + LAT);
    step();
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (8) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_read rsp: got none want tag=%0d dat=%h cyc=%0d", e.tag, e.dat, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.tag !== e.tag || o.dat !== e.dat || o.cyc != e.cyc) begin errors++;
          $display("FAIL single_read rsp: got tag=%0d dat=%h cyc=%0d want tag=%0d dat=%h cyc=%0d", o.tag, o.dat, o.cyc, e.tag, e.dat, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_read extra: got %0d unexpected responses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    rsp_t e, o;
    for (int k = 0; k < 8; k++) begin
      drive_d(1'b1, 1'b1, 16'h0100 + 16'(2 * k), 16'h1000 + 16'(k));
      step();
    end
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) begin
      drive_i(1'b1, 16'h0100 + 16'(2 * k));
      push_exp(1'b0, 16'h1000 + 16'(k), cyc + LAT);
      step();
      checks++; if (g_i !== 1'b1) begin errors++; $display("FAIL back_to_back i_grant[%0d]: got %b want 1", k, g_i); end
    end
    drive_i(1'b0, 16'h0);
    repeat (8) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL back_to_back rsp: got none want tag=%0d dat=%h cyc=%0d", e.tag, e.dat, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.tag !== e.tag || o.dat !== e.dat || o.cyc != e.cyc) begin errors++;
          $display("FAIL back_to_back rsp: got tag=%0d dat=%h cyc=%0d want tag=%0d dat=%h cyc=%0d", o.tag, o.dat, o.cyc, e.tag, e.dat, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL back_to_back extra: got %0d unexpected responses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  // Starts from reset, so last=I and D wins the first tie. D locks for 8 cycles; I takes over with no bubble.
  // Later ties then alternate: D first (I won most recently), then I.
  task automatic test_contention();
    rsp_t e, o;
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive_i(1'b1, 16'h0102);
      if (k < 8) begin
        drive_d(1'b1, 1'b0, 16'h0100 + 16'(2 * k), 16'h0);
        push_exp(1'b1, 16'h1000 + 16'(k), cyc + LAT);
      end else begin
        drive_d(1'b0, 1'b0, 16'h0, 16'h0);
        push_exp(1'b0, 16'h1001, cyc + LAT);
      end
      step();
      checks++; if (g_d !== (k < 8)) begin errors++; $display("FAIL contention d_grant[%0d]: got %b want %b", k, g_d, k < 8); end
      checks++; if (g_i !== (k == 8)) begin errors++; $display("FAIL contention i_grant[%0d]: got %b want %b", k, g_i, k == 8); end
    end
    drive_i(1'b0, 16'h0); step();
    drive_i(1'b1, 16'h0104); drive_d(1'b1, 1'b0, 16'h0100, 16'h0);
    push_exp(1'b1, 16'h1000, cyc + LAT);
    step();
    checks++; if (g_d !== 1'b1 || g_i !== 1'b0) begin errors++; $display("FAIL contention tie1: got i=%b d=%b want 0 1", g_i, g_d); end
    drive_i(1'b0, 16'h0); drive_d(1'b0, 1'b0, 16'h0, 16'h0); step();
    drive_i(1'b1, 16'h0104); drive_d(1'b1, 1'b0, 16'h0100, 16'h0);
    push_exp(1'b0, 16'h1002, cyc + LAT);
    step();
    checks++; if (g_i !== 1'b1 || g_d !== 1'b0) begin errors++; $display("FAIL contention tie2: got i=%b d=%b want 1 0", g_i, g_d); end
    drive_i(1'b0, 16'h0); drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (8) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL contention rsp: got none want tag=%0d dat=%h cyc=%0d", e.tag, e.dat, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.tag !== e.tag || o.dat !== e.dat || o.cyc != e.cyc) begin errors++;
          $display("FAIL contention rsp: got tag=%0d dat=%h cyc=%0d want tag=%0d dat=%h cyc=%0d", o.tag, o.dat, o.cyc, e.tag, e.dat, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL contention extra: got %0d unexpected responses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_write_ordering();
    rsp_t e, o;
    drive_d(1'b1, 1'b1, 16'h0040, 16'h5555); step();
    drive_d(1'b0, 1'b0, 16'h0, 16'h0); step();
    drive_d(1'b1, 1'b1, 16'h0040, 16'h1234); step();
    drive_d(1'b1, 1'b0, 16'h0040, 16'h0);
    push_exp(1'b1, 16'h1234, cyc + LAT);
    step();
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (8) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL write_ordering rsp: got none want tag=%0d dat=%h cyc=%0d", e.tag, e.dat, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.tag !== e.tag || o.dat !== e.dat || o.cyc != e.cyc) begin errors++;
          $display("FAIL write_ordering rsp: got tag=%0d dat=%h cyc=%0d want tag=%0d dat=%h cyc=%0d", o.tag, o.dat, o.cyc, e.tag, e.dat, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL write_ordering extra: got %0d unexpected responses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    for (int k = 0; k < 3; k++) begin
      drive_i(1'b1, 16'h0100 + 16'(2 * k));
      step();
    end
    drive_i(1'b0, 16'h0);
    rst = 1'b1; step();
    rst = 1'b0; step();
    checks++; if (o_iv !== 1'b0 || o_dv !== 1'b0 || o_id !== 16'h0 || o_dd !== 16'h0) begin errors++;
      $display("FAIL reset_mid outputs: got iv=%b dv=%b id=%h dd=%h want all 0", o_iv, o_dv, o_id, o_dd); end
    repeat (3) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_mid flushed: got %0d pulses in cycles 4-7 want 0", obs_q.size()); obs_q.delete(); end
    drive_d(1'b1, 1'b0, 16'h0010, 16'h0);
    push_exp(1'b1, 16'hBEEF, cyc + LAT);
    step();
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (8) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL reset_mid rsp: got none want tag=%0d dat=%h cyc=%0d", e.tag, e.dat, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.tag !== e.tag || o.dat !== e.dat || o.cyc != e.cyc) begin errors++;
          $display("FAIL reset_mid rsp: got tag=%0d dat=%h cyc=%0d want tag=%0d dat=%h cyc=%0d", o.tag, o.dat, o.cyc, e.tag, e.dat, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_mid extra: got %0d unexpected responses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  // 16-word instance: 0x0022 is word 0x11, which wraps to word 1, the same as 0x0002.
  task automatic test_addr_wrap();
    rsp_t o;
    int want_cyc;
    sm_obs_q.delete();
    smf.d_enable = 1'b1; smf.d_wr = 1'b1; smf.d_addr = 16'h0002; smf.d_data_in = 16'hAAAA;
    step();
    smf.d_wr = 1'b0; smf.d_addr = 16'h0022; smf.d_data_in = 16'h0000;
    want_cyc = cyc + LAT;
    step();
    smf.d_enable = 1'b0;
    repeat (8) step();
    checks++;
    if (sm_obs_q.size() != 1) begin errors++; $display("FAIL addr_wrap count: got %0d responses want 1", sm_obs_q.size()); end
    else begin
      o = sm_obs_q.pop_front();
      if (o.dat !== 16'hAAAA || o.cyc != want_cyc) begin errors++;
        $display("FAIL addr_wrap rsp: got dat=%h cyc=%0d want dat=aaaa cyc=%0d", o.dat, o.cyc, want_cyc); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_i(1'b0, 16'h0);
    drive_d(1'b0, 1'b0, 16'h0, 16'h0);
    smf.i_enable = 1'b0; smf.i_addr = 16'h0;
    smf.d_enable = 1'b0; smf.d_wr = 1'b0; smf.d_addr = 16'h0; smf.d_data_in = 16'h0;
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_write_ordering();
    test_reset_mid();
    test_addr_wrap();
    checks++; if (dual_cnt != 0) begin errors++; $display("FAIL dual_valid: got %0d cycles with both valids want 0", dual_cnt); end
    checks++; if (stray_cnt != 0) begin errors++; $display("FAIL idle_data_zero: got %0d cycles with nonzero data while invalid want 0", stray_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_mem_responder.md
# unified_mem_responder

Single-ported unified main-memory responder that serves both the instruction cache and the data cache fill/write traffic of the five-stage pipelined CPU. It is the memory side of the cache miss protocol: enable/wr/addr requests in, pipelined read data out with a one-cycle `data_valid` pulse after a fixed latency. A lock-while-enabled round-robin arbiter keeps an 8-word block fill from one cache contiguous. Reads are pipelined at one request per cycle.

## Interface
- `ADDR_W`, default 16: byte-address width. Bit 0 is ignored; memory is word (16-bit) addressed.
- `MEM_WORDS_LOG2`, default 15: log2 of the storage depth in words. The word index is `addr[MEM_WORDS_LOG2:1]`.
- `LATENCY`, default 4: read latency in cycles, from the accept cycle to the `data_valid` cycle. Legal range is 1–8.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_enable` in 1: I-cache read request.
- `i_addr` in ADDR_W: I-cache byte address.
- `i_grant` out 1: the I request is accepted this cycle (combinational).
- `i_data_out` out 16: I read data. It is 0 when `i_data_valid` is low.
- `i_data_valid` out 1: I read data valid (registered).
- `d_enable` in 1: D-cache request.
- `d_wr` in 1: D request is a write (qualified by `d_enable`).
- `d_addr` in ADDR_W: D-cache byte address.
- `d_data_in` in 16: D write data.
- `d_grant` out 1: the D request is accepted this cycle (combinational).
- `d_data_out` out 16: D read data. It is 0 when `d_data_valid` is low.
- `d_data_valid` out 1: D read data valid (registered).

## Operation
- **Accept rule.** A request is accepted in any cycle where `x_enable && x_grant`. At most one grant is high per cycle.
- **Arbiter state.**
  - `owner` ∈ {NONE, I, D}.
  - `last` ∈ {I, D}; its reset value is I, so D wins the first tie.
- **Grant logic (combinational).**
  - If `owner` is X and `x_enable` is high, grant X.
  - Otherwise grant the single active requester.
  - If both requesters are active, grant the one that is not `last`.
- **State update at each edge.**
  - `owner` becomes the granted requester, or NONE if nothing was granted.
  - `last` is updated whenever a grant changes ownership.
- **Lock.** An owner holding enable high keeps the grant indefinitely, so a block fill is never interleaved with the other requester.
- **Write** (`d_enable & d_wr & d_grant`):
  - Storage at the word index takes `d_data_in` at the accept edge.
  - No `data_valid` is produced.
- **Read:**
  - Storage is sampled at the accept cycle, with read-before-write semantics within the same cycle; only one access is possible per cycle anyway.
  - A tag (requester id) and the data travel down a `LATENCY`-deep shift pipeline of valid/tag/data.
  - At the tail, the matching port's `data_valid` pulses for one cycle with the data.
- **Ordering.**
  - A read accepted in the cycle after a write to the same address returns the new value.
  - Responses return in accept order.
  - Responses for a requester that has since lost its grant are still delivered.
- **Pipeline sharing.** The pipeline is shared by both requesters, so at most one `data_valid` is high per cycle.
- **Requester contract.** A requester may drop enable at any time; this does not cancel responses already accepted.
- **Addressing.** Addresses beyond the storage depth wrap modulo 2^MEM_WORDS_LOG2 words, because upper bits are ignored.
- **Reset.**
  - Clears all pipeline valid bits: in-flight reads are dropped and never return.
  - Sets `owner`=NONE, `last`=I, and both data outputs to 0.
  - Does not clear storage contents.

## Timing
- Read accepted in cycle n: `x_data_valid`=1 and data are presented in cycle n+LATENCY only. Both are registered outputs.
- Throughput is one accepted request per cycle, sustained. An 8-word fill issued back-to-back returns 8 consecutive valid cycles, n+4 … n+11.
- Grants are combinational from the enables, `owner` and `last`, with no combinational path from the data inputs.
- Ownership hand-off when the owner drops enable in cycle k: the other requester is granted in cycle k itself, with zero bubble.
- `rst` asserted in cycle k: in cycle k+1 all outputs read 0 and `owner` is NONE.
- Outputs after reset: `i_grant`/`d_grant` follow their enables per arbitration; `i_data_valid`=`d_data_valid`=0; `i_data_out`=`d_data_out`=0.

## Test plan
- **Single read.** D writes 0xBEEF to 0x0010 in cycle 0, then D reads 0x0010 in cycle 1.
  - Required: `d_data_valid` is high only in cycle 5 with `d_data_out`=0xBEEF, and `i_data_valid` stays 0.
- **Back-to-back fill.** I holds enable for 8 cycles with addresses 0x0100,0x0102,…,0x010E, after that storage was preloaded via D writes with values 0x1000+index.
  - Required: `i_data_valid` is high in cycles n+4 … n+11 with 0x1000 … 0x1007 in order.
- **Contention and lock.** Both enables rise in cycle 0; D holds enable for 8 cycles, I holds its enable continuously.
  - Required: `d_grant` in cycles 0–7, `i_grant`=0 in cycles 0–7 and 1 in cycle 8.
  - Required: a second simultaneous request after both drop is granted to I (round-robin).
- **Write ordering.** In cycle 0 D writes 0x1234 to 0x0040; in cycle 1 D reads 0x0040.
  - Required: the read in cycle 1 returns 0x1234 at cycle 5.
  - Required: the write produces no `data_valid` pulse.
- **Reset mid-operation.** Reads are accepted in cycles 0–2 and `rst` is asserted in cycle 3.
  - Required: no `data_valid` pulse in cycles 4–7.
  - Required: storage is retained, so a read issued afterwards still returns previously written data.
- **Address wrap.** With `MEM_WORDS_LOG2`=4, write 0xAAAA to 0x0002, then read 0x0022.
  - Required: the read returns 0xAAAA.
